// File: rtl/alu_operand_loader.sv
// Operand loader for four_bit_alu: one debounced pushbutton steps X, Y and F loads
// from a shared nibble input, then flags op_valid while the held operation is complete.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nibble_in,
    input  logic       btn_in,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic [1:0] f_out,
    output logic       op_valid,
    output logic [1:0] state_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_Y = 2'd1,
        LOAD_F = 2'd2,
        RUN    = 2'd3
    } state_t;

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    state_t           state_q, state_d;
    logic [3:0]       x_q, x_d;
    logic [3:0]       y_q, y_d;
    logic [1:0]       f_q, f_d;
    logic             valid_q, valid_d;

    // The level only flips after btn_sync has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = deb_d & ~deb_q;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        f_d     = f_q;
        valid_d = valid_q;
        if (press_q) begin
            case (state_q)
                LOAD_X: begin
                    x_d     = nibble_in;
                    state_d = LOAD_Y;
                end
                LOAD_Y: begin
                    y_d     = nibble_in;
                    state_d = LOAD_F;
                end
                LOAD_F: begin
                    f_d     = nibble_in[1:0];
                    valid_d = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    valid_d = 1'b0;
                    state_d = LOAD_X;
                end
                default: state_d = LOAD_X;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            state_q <= LOAD_X;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            f_q     <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign f_out     = f_q;
    assign op_valid  = valid_q;
    assign state_out = state_q;

endmodule
